// File: rtl/rf_sequencer.sv
// rf_sequencer: three-state instruction sequencer in front of an external
// register file. Each accepted instruction reads two registers, runs one ALU
// operation on them, writes the result back (unless rd is r0) and reports the
// result with carry/zero flags for one cycle.
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both 1. instr_ready is high only in IDLE, so at most one
// instruction is in flight. Inputs are don't-care whenever instr_ready is 0.
//
// Timing per instruction (E0 = accept edge):
//   READ cycle : rf_addr_a/b driven with the captured ra/rb
//   E1         : register file latches the read data
//   EXEC cycle : ALU runs on rf_data_a/b, write port driven
//   E2         : write commits in the file, result/carry/zero registered
//   next cycle : result_valid=1 (a new instruction may be accepted here)
module rf_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic [ADDR_W-1:0] rf_addr_a,
    output logic [ADDR_W-1:0] rf_addr_b,
    output logic [ADDR_W-1:0] rf_addr_d,
    output logic [DATA_W-1:0] rf_data_in,
    output logic              rf_write,
    input  logic [DATA_W-1:0] rf_data_a,
    input  logic [DATA_W-1:0] rf_data_b,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero,
    output logic              result_valid,
    // Debug view of the FSM: 0=IDLE, 1=READ, 2=EXEC
    output logic [1:0]        fsm_state
);

    // ALU operation codes
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MOV = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Captured instruction, stable through READ and EXEC
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [ADDR_W-1:0] ra_q;
    logic [ADDR_W-1:0] rb_q;

    // Combinational ALU outputs, meaningful only during EXEC
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   diff_ext;

    logic accept;

    assign accept    = (state == ST_IDLE) && instr_valid;
    assign fsm_state = state;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and all state-decoded outputs (register-file ports, ready)
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        rf_addr_a   = '0;
        rf_addr_b   = '0;
        rf_addr_d   = '0;
        rf_data_in  = '0;
        rf_write    = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                rf_addr_a  = ra_q;
                rf_addr_b  = rb_q;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                rf_addr_a  = ra_q;
                rf_addr_b  = rb_q;
                rf_addr_d  = rd_q;
                rf_data_in = alu_res;
                // r0 is never written; its result is still reported
                rf_write   = (rd_q != '0);
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Capture the offered instruction on the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
            rd_q <= '0;
            ra_q <= '0;
            rb_q <= '0;
        end else if (accept) begin
            op_q <= opcode;
            rd_q <= rd;
            ra_q <= ra;
            rb_q <= rb;
        end
    end

    // Widened add/subtract so the top bit gives carry-out / borrow directly
    assign sum_ext  = {1'b0, rf_data_a} + {1'b0, rf_data_b};
    assign diff_ext = {1'b0, rf_data_a} - {1'b0, rf_data_b};

    // ALU: result and carry for the captured opcode
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res   = sum_ext[DATA_W-1:0];
                alu_carry = sum_ext[DATA_W];
            end
            OP_SUB: begin
                alu_res   = diff_ext[DATA_W-1:0];
                alu_carry = diff_ext[DATA_W];
            end
            OP_AND: alu_res = rf_data_a & rf_data_b;
            OP_OR:  alu_res = rf_data_a | rf_data_b;
            OP_XOR: alu_res = rf_data_a ^ rf_data_b;
            OP_NOT: alu_res = ~rf_data_a;
            OP_SHL: begin
                alu_res   = {rf_data_a[DATA_W-2:0], 1'b0};
                alu_carry = rf_data_a[DATA_W-1];
            end
            OP_MOV: alu_res = rf_data_a;
            default: begin
                alu_res   = '0;
                alu_carry = 1'b0;
            end
        endcase
    end

    // Register result and flags at the edge ending EXEC; hold until the next EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
        end else if (state == ST_EXEC) begin
            result <= alu_res;
            carry  <= alu_carry;
            zero   <= (alu_res == '0);
        end
    end

    // One-cycle result_valid pulse following EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_valid <= 1'b0;
        end else begin
            result_valid <= (state == ST_EXEC);
        end
    end

endmodule

// File: tb/tb_rf_sequencer.sv
// Bench for rf_sequencer: directed scenarios followed by randomized
// instructions, checked against an arithmetic reference model.
module tb_rf_sequencer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 1 << ADDR_W;
    localparam int MASK   = (1 << DATA_W) - 1;

    // clock / reset
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DUT signals
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [ADDR_W-1:0] rf_addr_a;
    logic [ADDR_W-1:0] rf_addr_b;
    logic [ADDR_W-1:0] rf_addr_d;
    logic [DATA_W-1:0] rf_data_in;
    logic              rf_write;
    logic [DATA_W-1:0] rf_data_a;
    logic [DATA_W-1:0] rf_data_b;
    logic [DATA_W-1:0] result;
    logic              carry;
    logic              zero;
    logic              result_valid;
    logic [1:0]        fsm_state;

    rf_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .opcode       (opcode),
        .rd           (rd),
        .ra           (ra),
        .rb           (rb),
        .rf_addr_a    (rf_addr_a),
        .rf_addr_b    (rf_addr_b),
        .rf_addr_d    (rf_addr_d),
        .rf_data_in   (rf_data_in),
        .rf_write     (rf_write),
        .rf_data_a    (rf_data_a),
        .rf_data_b    (rf_data_b),
        .result       (result),
        .carry        (carry),
        .zero         (zero),
        .result_valid (result_valid),
        .fsm_state    (fsm_state)
    );

    // Register file attached to the DUT: registered reads, synchronous write
    logic [DATA_W-1:0] tb_rf [NREGS];

    always @(posedge clk) begin
        rf_data_a <= tb_rf[rf_addr_a];
        rf_data_b <= tb_rf[rf_addr_b];
        if (rf_write === 1'b1) tb_rf[rf_addr_d] <= rf_data_in;
    end

    // Reference model state and bookkeeping
    int model_regs [NREGS];
    int last_res;
    int n_cmp;
    int n_err;

    // Compare one observed value with its expected value
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference ALU from the operation table, plain integer arithmetic
    task automatic alu_ref(input int op, input int a, input int b, output int r, output int c);
        int s;
        c = 0;
        case (op)
            0: begin s = a + b; r = s & MASK; c = (s > MASK) ? 1 : 0; end
            1: begin r = (a - b + MASK + 1) & MASK; c = (a < b) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = MASK - a;
            6: begin r = (a * 2) & MASK; c = (a >= (MASK + 1) / 2) ? 1 : 0; end
            default: r = a;
        endcase
    endtask

    // Put random don't-care values on the instruction inputs
    task automatic drive_garbage();
        instr_valid = 1'($urandom_range(0, 1));
        opcode      = 3'($urandom_range(0, 7));
        rd          = ADDR_W'($urandom_range(0, NREGS - 1));
        ra          = ADDR_W'($urandom_range(0, NREGS - 1));
        rb          = ADDR_W'($urandom_range(0, NREGS - 1));
    endtask

    // Issue one instruction starting at a falling edge; returns at the falling
    // edge of the result_valid cycle, so a following call is back-to-back.
    task automatic do_instr(input int op, input int d, input int a, input int b);
        int guard;
        int exp_r;
        int exp_c;
        guard = 0;
        while (instr_ready !== 1'b1 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", instr_ready, 1);
        alu_ref(op, model_regs[a], model_regs[b], exp_r, exp_c);
        instr_valid = 1'b1;
        opcode      = op[2:0];
        rd          = d[ADDR_W-1:0];
        ra          = a[ADDR_W-1:0];
        rb          = b[ADDR_W-1:0];
        @(posedge clk);
        @(negedge clk);
        drive_garbage();
        check("read_state",   fsm_state,    1);
        check("read_ready",   instr_ready,  0);
        check("read_addr_a",  rf_addr_a,    a);
        check("read_addr_b",  rf_addr_b,    b);
        check("read_wr",      rf_write,     0);
        check("read_rvalid",  result_valid, 0);
        @(negedge clk);
        drive_garbage();
        check("exec_state",   fsm_state,    2);
        check("exec_addr_a",  rf_addr_a,    a);
        check("exec_addr_b",  rf_addr_b,    b);
        check("exec_wr",      rf_write,     (d != 0) ? 1 : 0);
        check("exec_addr_d",  rf_addr_d,    d);
        check("exec_data_in", rf_data_in,   exp_r);
        @(negedge clk);
        instr_valid = 1'b0;
        check("post_rvalid",  result_valid, 1);
        check("post_ready",   instr_ready,  1);
        check("post_wr",      rf_write,     0);
        check("post_result",  result,       exp_r);
        check("post_carry",   carry,        exp_c);
        check("post_zero",    zero,         (exp_r == 0) ? 1 : 0);
        if (d != 0) model_regs[d] = exp_r;
        last_res = exp_r;
    endtask

    // Idle for n cycles; result must stay held and result_valid low
    task automatic idle_cycles(input int n);
        instr_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_rvalid", result_valid, 0);
            check("idle_hold",   result,       last_res);
            check("idle_ready",  instr_ready,  1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  instr_ready,  1);
        check({tag, "_state"},  fsm_state,    0);
        check({tag, "_wr"},     rf_write,     0);
        check({tag, "_addr_a"}, rf_addr_a,    0);
        check({tag, "_addr_b"}, rf_addr_b,    0);
        check({tag, "_addr_d"}, rf_addr_d,    0);
        check({tag, "_din"},    rf_data_in,   0);
        check({tag, "_result"}, result,       0);
        check({tag, "_carry"},  carry,        0);
        check({tag, "_zero"},   zero,         0);
        check({tag, "_rvalid"}, result_valid, 0);
    endtask

    initial begin
        int init_vals [NREGS];
        n_cmp    = 0;
        n_err    = 0;
        last_res = 0;
        init_vals = '{8'h00, 8'hF0, 8'h20, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        for (int i = 0; i < NREGS; i++) begin
            tb_rf[i]      = init_vals[i][DATA_W-1:0];
            model_regs[i] = init_vals[i];
        end
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        opcode      = '0;
        rd          = '0;
        ra          = '0;
        rb          = '0;

        // Reset: outputs during and after reset
        #2;
        check_reset_outputs("rst_low");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_rel");

        // ADD r3 = r1 + r2 = 0x10 with carry-out
        do_instr(0, 3, 1, 2);
        check("add_const_res",   result, 8'h10);
        check("add_const_carry", carry,  1);
        idle_cycles(2);

        // SUB with borrow, then without
        do_instr(1, 4, 2, 1);
        check("sub_b_const_res",   result, 8'h30);
        check("sub_b_const_carry", carry,  1);
        idle_cycles(1);
        do_instr(1, 4, 1, 2);
        check("sub_const_res",   result, 8'hD0);
        check("sub_const_carry", carry,  0);
        idle_cycles(1);

        // XOR into r0: no write, zero flag set
        do_instr(4, 0, 1, 1);
        check("r0_const_zero", zero, 1);
        check("r0_unchanged",  tb_rf[0], model_regs[0]);
        idle_cycles(1);

        // Hazard: set r3 to something else, ADD into r3, MOV r5=r3 back-to-back
        do_instr(5, 3, 3, 0);
        do_instr(0, 3, 1, 2);
        do_instr(7, 5, 3, 0);
        check("hazard_r5", tb_rf[5], 8'h10);
        idle_cycles(1);

        // Reset pulled low during EXEC: write must drop at once, no result
        instr_valid = 1'b1;
        opcode      = 3'b000;
        rd          = 3'd6;
        ra          = 3'd1;
        rb          = 3'd2;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check("mid_exec_state", fsm_state, 2);
        check("mid_exec_wr",    rf_write,  1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n    = 1'b1;
        last_res = 0;
        @(negedge clk);
        check("mid_rst_rvalid", result_valid, 0);
        check("mid_rst_state",  fsm_state,    0);
        check("mid_rst_r6",     tb_rf[6],     model_regs[6]);
        idle_cycles(1);

        // Randomized instructions with random gaps
        for (int k = 0; k < 40; k++) begin
            do_instr($urandom_range(0, 7), $urandom_range(0, NREGS - 1),
                     $urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1));
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(0, 2));
        end
        idle_cycles(1);

        // Final register-file contents against the model
        for (int i = 0; i < NREGS; i++) begin
            check($sformatf("final_r%0d", i), tb_rf[i], model_regs[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
